apb_reg_slave: RTL and testbench
================================

# apb_reg_slave

APB slave register bank that sits directly downstream of the APB master: it consumes psel/penable/paddr/pwrite/pwdata and returns pready/prdata/pslverr. Holds NUM_REGS 32-bit read/write registers at word-aligned addresses starting at BASE_ADDR. Inserts a fixed, parameterised number of wait states per access, so the master's pready-wait path gets exercised. Flags out-of-range or misaligned addresses with pslverr.

## Interface
- NUM_REGS, 16, number of 32-bit registers (2..256)
- WAIT_CYCLES, 2, wait states inserted in every access phase (0..15)
- BASE_ADDR, 32'h0, byte address of register 0; must be 4-byte aligned
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset; clears all state while 0
- psel_i  input  1  slave select from master
- penable_i  input  1  access-phase indicator from master
- paddr_i  input  32  byte address
- pwrite_i  input  1  1 = write, 0 = read
- pwdata_i  input  32  write data
- pready_o  output  1  transfer completes in this cycle
- prdata_o  output  32  read data, valid while pready_o=1 and a read is in progress
- pslverr_o  output  1  error response, valid only while pready_o=1

## Operation
- Registers reg[0..NUM_REGS-1], all reset to 32'h0.
- Decode: off = paddr_i - BASE_ADDR (32-bit unsigned wrap); the access is valid iff off[1:0]==0 and off[31:2] < NUM_REGS; index = off[31:2].
- FSM states: IDLE, WAIT, READY.
- IDLE: on a setup cycle (psel_i=1, penable_i=0), latch addr, write flag, wdata and the decode result. Next state is READY if WAIT_CYCLES==0; otherwise WAIT with cnt=WAIT_CYCLES.
- IDLE with psel_i=1 and penable_i=1 (no setup seen): ignored, stay IDLE.
- WAIT: cnt decrements each cycle. When cnt==1, next state is READY.
- WAIT or READY with psel_i=0 (master abort): return to IDLE. No write, no response.
- READY: pready_o=1.
  - Valid write: reg[index] <= latched wdata at the clock edge ending the READY cycle.
  - Invalid access: pslverr_o=1, no register change, prdata_o=0.
  - Next state is always IDLE.
- Read data: prdata_o is registered. It loads reg[index] (or 0 if invalid or a write) on the edge entering READY, and is 0 in every other state.
- Back-to-back: a new setup cycle immediately after READY is accepted from IDLE in that cycle.
- Latched wdata is used, not live pwdata_i.

## Timing
- Reset values: pready_o=0, prdata_o=0, pslverr_o=0, state=IDLE, cnt=0, all regs 0. Reset takes effect immediately and asynchronously; an in-flight access is dropped with no write.
- With setup cycle T1, access phase starts at T2. pready_o is high in cycle T2+WAIT_CYCLES, for exactly one cycle.
- Transfer length: 2+WAIT_CYCLES cycles, setup through completion.
- Read-after-write to the same register in the next transfer returns the new value.
- pready_o, prdata_o and pslverr_o are pure functions of registered state; no combinational path from inputs.

## Test plan
- Reset, then write 32'hDEAD_BEEF to BASE_ADDR+4 with WAIT_CYCLES=2 -> pready_o high exactly in cycle T2+2, pslverr_o=0. A following read of +4 returns 32'hDEAD_BEEF on prdata_o in its pready cycle.
- WAIT_CYCLES=0: read of BASE_ADDR+0 after reset -> pready_o high in T2, prdata_o=0. Write 32'h5 then read -> 32'h5, with back-to-back transfers and no idle cycle between them.
- Read of BASE_ADDR+NUM_REGS*4 and of BASE_ADDR+2 -> pslverr_o=1 and prdata_o=0 in the pready cycle. A write to either leaves all regs unchanged, checked by reading back all 16.
- Write 32'hA5A5_A5A5 to +8, with psel_i dropped during WAIT -> pready_o never asserts, FSM returns to IDLE, reg[2] still 0.
- Write in progress: assert reset low during WAIT, release, then read +8 -> outputs 0 during reset, read returns 0.
- Random mix of 10 alternating reads and writes with random data, checked against a scoreboard model -> every read matches and every pready pulse is 1 cycle wide.

Source files
------------

// File: rtl/apb_reg_slave.sv
// APB register bank slave with fixed wait-state insertion.
// Flags out-of-range or misaligned accesses with pslverr.
module apb_reg_slave #(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [31:0] paddr_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic        pready_o,
  output logic [31:0] prdata_o,
  output logic        pslverr_o
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READY
  } state_t;

  typedef struct packed {
    logic          ok;
    logic          wr;
    logic [IW-1:0] idx;
    logic [31:0]   wdata;
  } req_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  req_t          req_q, req_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   regs [NUM_REGS];
  logic [31:0]   off;
  logic          dec_ok;
  logic [IW-1:0] dec_idx;
  logic          wr_en;

  assign off     = paddr_i - BASE_ADDR;
  assign dec_ok  = (off[1:0] == 2'b00) &&
                   (off[31:2] < 30'(NUM_REGS));
  assign dec_idx = off[IW+1:2];

  // next state, wait counter, request latch and read-data load
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = '0;
    wr_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (psel_i && !penable_i) begin
          req_d.ok    = dec_ok;
          req_d.wr    = pwrite_i;
          req_d.idx   = dec_idx;
          req_d.wdata = pwdata_i;
          if (WAIT_CYCLES == 0) begin
            state_d = S_READY;
            if (dec_ok && !pwrite_i)
              rdata_d = regs[dec_idx];
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        if (!psel_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = S_READY;
          cnt_d   = '0;
          if (req_q.ok && !req_q.wr)
            rdata_d = regs[req_q.idx];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_READY: begin
        state_d = S_IDLE;
        wr_en   = psel_i && req_q.ok && req_q.wr;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // control state and registered read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  // register bank, written at the end of a completing write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[req_q.idx] <= req_q.wdata;
    end
  end

  assign pready_o  = (state_q == S_READY);
  assign pslverr_o = (state_q == S_READY) && !req_q.ok;
  assign prdata_o  = rdata_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: two instances (2 and 0 wait states)
// checked every cycle against a transaction-level register model.
module tb_apb_reg_slave;

  localparam int          NR    = 16;
  localparam int          W0    = 2;
  localparam int          W1    = 0;
  localparam logic [31:0] BASE0 = 32'h0;
  localparam logic [31:0] BASE1 = 32'h1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        psel    [2] = '{1'b0, 1'b0};
  logic        penable [2] = '{1'b0, 1'b0};
  logic        pwrite  [2] = '{1'b0, 1'b0};
  logic [31:0] paddr   [2] = '{32'h0, 32'h0};
  logic [31:0] pwdata  [2] = '{32'h0, 32'h0};
  logic        pready  [2];
  logic        pslverr [2];
  logic [31:0] prdata  [2];

  logic        e_rdy [2] = '{1'b0, 1'b0};
  logic        e_err [2] = '{1'b0, 1'b0};
  logic [31:0] e_rd  [2] = '{32'h0, 32'h0};
  logic [31:0] model [2][NR];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  apb_reg_slave #(
    .NUM_REGS(NR), .WAIT_CYCLES(W0), .BASE_ADDR(BASE0)
  ) u_w2 (
    .clk(clk), .reset(reset),
    .psel_i(psel[0]), .penable_i(penable[0]),
    .paddr_i(paddr[0]), .pwrite_i(pwrite[0]),
    .pwdata_i(pwdata[0]), .pready_o(pready[0]),
    .prdata_o(prdata[0]), .pslverr_o(pslverr[0])
  );

  apb_reg_slave #(
    .NUM_REGS(NR), .WAIT_CYCLES(W1), .BASE_ADDR(BASE1)
  ) u_w0 (
    .clk(clk), .reset(reset),
    .psel_i(psel[1]), .penable_i(penable[1]),
    .paddr_i(paddr[1]), .pwrite_i(pwrite[1]),
    .pwdata_i(pwdata[1]), .pready_o(pready[1]),
    .prdata_o(prdata[1]), .pslverr_o(pslverr[1])
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic clr_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NR; i++)
        model[d][i] = '0;
  endtask

  task automatic exp_idle(input int d);
    e_rdy[d] = 1'b0;
    e_err[d] = 1'b0;
    e_rd[d]  = '0;
  endtask

  // every cycle, both slaves against the model's expected outputs
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("pready%0d t=%0t", d, $time),
          {31'b0, pready[d]}, {31'b0, e_rdy[d]});
      chk($sformatf("pslverr%0d t=%0t", d, $time),
          {31'b0, pslverr[d]}, {31'b0, e_err[d]});
      chk($sformatf("prdata%0d t=%0t", d, $time),
          prdata[d], e_rd[d]);
    end
  end

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
      exp_idle(d);
    end
  endtask

  // one APB transfer; abort_k >= 0 drops psel in access cycle abort_k
  task automatic xfer(input int d,
                      input logic [31:0] addr,
                      input logic wr,
                      input logic [31:0] wdata,
                      input int abort_k,
                      output logic [31:0] rd,
                      output logic err);
    int          w;
    logic [31:0] off;
    logic        ok;
    int          idx;
    bit          aborted;
    w   = (d == 0) ? W0 : W1;
    off = addr - ((d == 0) ? BASE0 : BASE1);
    ok  = (off % 4 == 0) && (off / 4 < NR);
    idx = ok ? int'(off / 4) : 0;
    rd  = '0;
    err = 1'b0;
    aborted = 1'b0;
    @(posedge clk); #1;
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    paddr[d]   = addr;
    pwrite[d]  = wr;
    pwdata[d]  = wdata;
    exp_idle(d);
    for (int k = 0; k <= w; k++) begin
      @(posedge clk); #1;
      penable[d] = 1'b1;
      pwdata[d]  = ~wdata;
      if (k == abort_k) begin
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        exp_idle(d);
        aborted    = 1'b1;
        break;
      end
      e_rdy[d] = (k == w);
      e_err[d] = (k == w) && !ok;
      e_rd[d]  = (k == w && ok && !wr) ? model[d][idx] : '0;
      if (k == w) begin
        @(negedge clk);
        rd  = prdata[d];
        err = pslverr[d];
      end
    end
    if (!aborted && ok && wr)
      model[d][idx] = wdata;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] wa;
    clr_model();
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle(0, 2);

    // 2 wait states: write then read-after-write
    xfer(0, 32'h4, 1'b1, 32'hDEAD_BEEF, -1, rd, er);
    chk("wr4_err", {31'b0, er}, 32'h0);
    xfer(0, 32'h4, 1'b0, 32'h0, -1, rd, er);
    chk("rd4_data", rd, 32'hDEAD_BEEF);
    chk("model_reg1", model[0][1], 32'hDEAD_BEEF);
    idle(0, 1);

    // out-of-range and misaligned accesses
    xfer(0, NR * 4, 1'b0, 32'h0, -1, rd, er);
    chk("oor_rd_err", {31'b0, er}, 32'h1);
    chk("oor_rd_data", rd, 32'h0);
    xfer(0, 32'h2, 1'b0, 32'h0, -1, rd, er);
    chk("mis_rd_err", {31'b0, er}, 32'h1);
    chk("mis_rd_data", rd, 32'h0);
    xfer(0, NR * 4, 1'b1, 32'h1111_2222, -1, rd, er);
    xfer(0, 32'h2, 1'b1, 32'h3333_4444, -1, rd, er);
    for (int i = 0; i < NR; i++)
      xfer(0, 32'(i * 4), 1'b0, 32'h0, -1, rd, er);
    idle(0, 1);

    // master abort during the wait phase
    xfer(0, 32'h8, 1'b1, 32'hA5A5_A5A5, 1, rd, er);
    idle(0, 2);
    xfer(0, 32'h8, 1'b0, 32'h0, -1, rd, er);
    chk("abort_rd8", rd, 32'h0);
    idle(0, 1);

    // reset asserted in the middle of a write
    @(posedge clk); #1;
    psel[0]    = 1'b1;
    penable[0] = 1'b0;
    paddr[0]   = 32'h8;
    pwrite[0]  = 1'b1;
    pwdata[0]  = 32'h1234_5678;
    exp_idle(0);
    @(posedge clk); #1;
    penable[0] = 1'b1;
    #2 reset = 1'b0;
    clr_model();
    @(posedge clk); #1;
    psel[0]    = 1'b0;
    penable[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    idle(0, 1);
    xfer(0, 32'h8, 1'b0, 32'h0, -1, rd, er);
    chk("rst_rd8", rd, 32'h0);
    xfer(0, 32'h4, 1'b0, 32'h0, -1, rd, er);
    chk("rst_rd4", rd, 32'h0);

    // alternating random writes and reads
    wa = '0;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        wa = 32'($urandom_range(0, NR - 1) * 4);
        xfer(0, wa, 1'b1, $urandom, -1, rd, er);
      end else if (i % 4 == 1) begin
        xfer(0, wa, 1'b0, 32'h0, -1, rd, er);
      end else begin
        xfer(0, 32'($urandom_range(0, NR - 1) * 4),
             1'b0, 32'h0, -1, rd, er);
      end
    end
    idle(0, 2);

    // zero wait states, back-to-back transfers
    xfer(1, BASE1, 1'b0, 32'h0, -1, rd, er);
    chk("w0_rd0_init", rd, 32'h0);
    xfer(1, BASE1, 1'b1, 32'h5, -1, rd, er);
    xfer(1, BASE1, 1'b0, 32'h0, -1, rd, er);
    chk("w0_rd0_new", rd, 32'h5);
    xfer(1, BASE1 + NR * 4, 1'b0, 32'h0, -1, rd, er);
    chk("w0_oor_err", {31'b0, er}, 32'h1);
    idle(1, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
